// File: rtl/jt7759_romfetch_if.sv
// jt7759 ROM port plus word-memory handshake bundle.
// slave: the fetch unit. master: the chip/memory side.
interface jt7759_romfetch_if;
    logic        rom_cs;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_dout;

    modport slave (
        input  rom_cs, rom_addr, mem_ack, mem_dout,
        output rom_data, rom_ok, mem_req, mem_addr
    );

    modport master (
        output rom_cs, rom_addr, mem_ack, mem_dout,
        input  rom_data, rom_ok, mem_req, mem_addr
    );
endinterface

// File: rtl/jt7759_romfetch.sv
// jt7759 sample-ROM responder: two-word buffer (cur + prefetched nxt)
// filled from a req/ack word memory.
// Ports: clk, rstn (async low), flush (sync invalidate),
//   bus.slave: rom_cs/rom_addr -> rom_data/rom_ok;
//   mem_req/mem_addr -> mem_ack/mem_dout.
module jt7759_romfetch #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    jt7759_romfetch_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PREF
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] tag;
        logic        valid;
    } buf_t;

    state_t      st_q, st_d;
    buf_t        cur_q, cur_d;
    buf_t        nxt_q, nxt_d;
    logic        drop_q, drop_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;

    logic [15:0] word;
    logic [15:0] cur_inc;
    logic        hit_c, hit_n, miss;
    logic        pref_need;
    logic        keep;
    logic [15:0] sel;

    assign word    = bus.rom_addr[16:1];
    assign cur_inc = cur_q.tag + 16'd1;
    assign hit_c   = cur_q.valid && (cur_q.tag == word);
    assign hit_n   = nxt_q.valid && (nxt_q.tag == word);
    assign miss    = !(hit_c || hit_n);

    assign pref_need = PREFETCH && cur_q.valid &&
                       !(nxt_q.valid && (nxt_q.tag == cur_inc));

    // A word that lands after (or with) a flush is stale.
    assign keep = !drop_q && !flush;

    always_comb begin
        sel = 16'h0000;
        if (hit_c)
            sel = cur_q.data;
        else if (hit_n)
            sel = nxt_q.data;
    end

    assign bus.rom_ok   = bus.rom_cs && (hit_c || hit_n);
    assign bus.rom_data = !bus.rom_ok   ? 8'h00 :
                          bus.rom_addr[0] ? sel[15:8] : sel[7:0];
    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;

    always_comb begin
        st_d   = st_q;
        cur_d  = cur_q;
        nxt_d  = nxt_q;
        drop_d = drop_q;
        req_d  = req_q;
        addr_d = addr_q;

        case (st_q)
            IDLE: begin
                // No new request on a flush edge, so nothing
                // derived from pre-flush contents goes out.
                if (!flush) begin
                    if (bus.rom_cs && miss) begin
                        addr_d = word;
                        req_d  = 1'b1;
                        st_d   = FETCH;
                    end else if (bus.rom_cs && hit_n && !hit_c) begin
                        cur_d       = nxt_q;
                        nxt_d.valid = 1'b0;
                    end else if (pref_need) begin
                        addr_d = cur_inc;
                        req_d  = 1'b1;
                        st_d   = PREF;
                    end
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    if (keep) begin
                        cur_d.data  = bus.mem_dout;
                        cur_d.tag   = addr_q;
                        cur_d.valid = 1'b1;
                        nxt_d.valid = 1'b0;
                    end
                    drop_d = 1'b0;
                    req_d  = 1'b0;
                    st_d   = IDLE;
                end
            end
            PREF: begin
                if (bus.mem_ack) begin
                    if (keep) begin
                        nxt_d.data  = bus.mem_dout;
                        nxt_d.tag   = addr_q;
                        nxt_d.valid = 1'b1;
                    end
                    drop_d = 1'b0;
                    req_d  = 1'b0;
                    st_d   = IDLE;
                end
            end
            default: begin
                st_d  = IDLE;
                req_d = 1'b0;
            end
        endcase

        if (flush) begin
            cur_d.valid = 1'b0;
            nxt_d.valid = 1'b0;
            if ((st_q != IDLE) && !bus.mem_ack)
                drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q   <= IDLE;
            cur_q  <= '0;
            nxt_q  <= '0;
            drop_q <= 1'b0;
            req_q  <= 1'b0;
            addr_q <= 16'h0000;
        end else begin
            st_q   <= st_d;
            cur_q  <= cur_d;
            nxt_q  <= nxt_d;
            drop_q <= drop_d;
            req_q  <= req_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: tb/tb_jt7759_romfetch.sv
// Directed bench for jt7759_romfetch with a latency-programmable
// word memory and a queue of expected memory requests.
module tb_jt7759_romfetch;

    logic clk = 1'b0;
    logic rstn;
    logic flush;

    jt7759_romfetch_if ifc();

    jt7759_romfetch #(.PREFETCH(1'b1)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          failures   = 0;
    int          lat        = 1;
    bit          ack_toggle = 1'b1;
    int          acks_done  = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0008: return 16'hBEEF;
            16'h0100: return 16'h1234;
            default:  return a ^ 16'h5AA5;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [16:0] a);
        logic [15:0] w;
        w = mem_word(a[16:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks lat+1 steps after a request appears and
    // checks each new request against the expected-address queue.
    initial begin
        bit          busy;
        int          cnt;
        logic [15:0] held;
        logic [15:0] e;
        busy = 1'b0;
        cnt  = 0;
        held = 16'h0;
        ifc.mem_ack  = 1'b0;
        ifc.mem_dout = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_toggle) begin
                ifc.mem_ack = ~ifc.mem_ack;
                busy = 1'b0;
            end else begin
                if (ifc.mem_ack && busy)
                    acks_done++;
                ifc.mem_ack = 1'b0;
                if (!ifc.mem_req) begin
                    busy = 1'b0;
                end else begin
                    if (!busy) begin
                        busy = 1'b1;
                        cnt  = 0;
                        held = ifc.mem_addr;
                        chk("sb_req_expected", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("sb_req_addr", 32'(ifc.mem_addr), 32'(e));
                        end
                    end else begin
                        chk("req_addr_stable", 32'(ifc.mem_addr), 32'(held));
                    end
                    if (cnt == lat) begin
                        ifc.mem_ack  = 1'b1;
                        ifc.mem_dout = mem_word(held);
                    end
                    cnt++;
                end
            end
        end
    end

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ifc.rom_ok)
                return;
        end
        chk(tag, 32'(ifc.rom_ok), 1);
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ifc.mem_req)
                quiet++;
            else
                quiet = 0;
            if (quiet == 4)
                return;
        end
        chk(tag, 32'(ifc.mem_req), 0);
    endtask

    task automatic wait_req(input string tag, input logic [15:0] a);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.mem_req && ifc.mem_addr == a)
                return;
        end
        chk(tag, 32'(ifc.mem_addr), 32'(a));
    endtask

    // Expects rom_ok low until n more acks land, then the byte.
    task automatic wait_after_acks(input string tag, input int base,
                                   input int n, input logic [7:0] d);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (acks_done - base < n) begin
                chk({tag, "_low"}, 32'(ifc.rom_ok), 0);
            end else begin
                chk({tag, "_ok"}, 32'(ifc.rom_ok), 1);
                chk({tag, "_data"}, 32'(ifc.rom_data), 32'(d));
                done = 1'b1;
            end
        end
        if (!done)
            chk({tag, "_timeout"}, 32'(acks_done - base), 32'(n));
    endtask

    initial begin
        int          base;
        logic [16:0] a;

        // Reset with chip requesting and ack toggling.
        rstn         = 1'b0;
        flush        = 1'b0;
        ifc.rom_cs   = 1'b1;
        ifc.rom_addr = 17'h00010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mem_req", 32'(ifc.mem_req), 0);
            chk("rst_mem_addr", 32'(ifc.mem_addr), 0);
            chk("rst_rom_ok", 32'(ifc.rom_ok), 0);
            chk("rst_rom_data", 32'(ifc.rom_data), 0);
        end
        ack_toggle = 1'b0;
        ifc.rom_cs = 1'b0;
        rstn       = 1'b1;
        repeat (3) drive_step();

        // Cold miss with BEEF, then odd byte and prefetch of 9.
        lat = 2;
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0009);
        base = acks_done;
        ifc.rom_cs   = 1'b1;
        ifc.rom_addr = 17'h00010;
        @(negedge clk);
        chk("cold_ok_before", 32'(ifc.rom_ok), 0);
        wait_ok("cold_fill_timeout", 20);
        chk("cold_ack_count", 32'(acks_done - base), 1);
        chk("cold_data_lo", 32'(ifc.rom_data), 32'h00EF);
        drive_step();
        ifc.rom_addr = 17'h00011;
        @(negedge clk);
        chk("cold_ok_hi", 32'(ifc.rom_ok), 1);
        chk("cold_data_hi", 32'(ifc.rom_data), 32'h00BE);
        wait_idle("cold_idle_timeout");
        chk("cold_sb_empty", 32'(exp_q.size()), 0);

        // Streaming 0x10..0x1F, one byte per 4 cycles, latency 1.
        drive_step();
        ifc.rom_cs = 1'b0;
        flush      = 1'b1;
        drive_step();
        flush = 1'b0;
        lat   = 1;
        for (int w = 8; w <= 16; w++)
            exp_q.push_back(16'(w));
        ifc.rom_cs   = 1'b1;
        ifc.rom_addr = 17'h00010;
        wait_ok("stream_fill_timeout", 20);
        for (int b = 16'h10; b <= 16'h1F; b++) begin
            a = 17'(b);
            if (b != 16'h10) begin
                drive_step();
                ifc.rom_addr = a;
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("stream_ok", 32'(ifc.rom_ok), 1);
                chk("stream_data", 32'(ifc.rom_data), 32'(exp_byte(a)));
            end
        end
        wait_idle("stream_idle_timeout");
        chk("stream_sb_empty", 32'(exp_q.size()), 0);

        // Wrap: word FFFF prefetches word 0000.
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        drive_step();
        ifc.rom_addr = 17'h1FFFE;
        wait_ok("wrap_fill_timeout", 20);
        chk("wrap_data", 32'(ifc.rom_data), 32'(exp_byte(17'h1FFFE)));
        wait_idle("wrap_idle_timeout");
        chk("wrap_sb_empty", 32'(exp_q.size()), 0);
        exp_q.push_back(16'h0001);
        drive_step();
        ifc.rom_addr = 17'h00000;
        @(negedge clk);
        chk("wrap_nxt_ok", 32'(ifc.rom_ok), 1);
        chk("wrap_nxt_data", 32'(ifc.rom_data), 32'(exp_byte(17'h00000)));
        chk("wrap_no_demand", 32'(ifc.mem_req), 0);
        wait_idle("wrap2_idle_timeout");

        // Flush while a demand fetch is outstanding.
        drive_step();
        ifc.rom_cs = 1'b0;
        lat = 3;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        base = acks_done;
        ifc.rom_cs   = 1'b1;
        ifc.rom_addr = 17'h00200;
        wait_req("flush_req_timeout", 16'h0100);
        drive_step();
        flush = 1'b1;
        drive_step();
        flush = 1'b0;
        wait_after_acks("flush", base, 2, 8'h34);
        wait_idle("flush_idle_timeout");
        chk("flush_sb_empty", 32'(exp_q.size()), 0);

        // Address jump while prefetching word 9.
        drive_step();
        ifc.rom_cs = 1'b0;
        flush      = 1'b1;
        drive_step();
        flush = 1'b0;
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h2001);
        ifc.rom_cs   = 1'b1;
        ifc.rom_addr = 17'h00010;
        wait_ok("jump_fill_timeout", 30);
        wait_req("jump_pref_timeout", 16'h0009);
        drive_step();
        ifc.rom_addr = 17'h04000;
        base = acks_done;
        wait_after_acks("jump", base, 2, exp_byte(17'h04000));
        wait_idle("jump_idle_timeout");
        chk("final_sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
